// File: rtl/avalon_pkg.sv
// rtl/avalon_pkg.sv - shared types, response codes and default widths for the Avalon burst master
package avalon_pkg;

  localparam int DEF_ADDR_W      = 13;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_BURST   = 512;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int BCNT_W          = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY        = 2'b00,
    RESP_SLVERR      = 2'b10,
    RESP_DECODEERROR = 2'b11
  } resp_t;

  function automatic logic len_valid(input logic [BCNT_W-1:0] len, input int max_len);
    return (len != '0) && (32'(len) <= 32'(max_len));
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// rtl/burst_beat_counter.sv - beat counter: loads burst length, counts accepted beats, flags the last one
module burst_beat_counter
  import avalon_pkg::*;
#(
  parameter int W = BCNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_len,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  logic [W-1:0] r_count;
  logic [W-1:0] r_len;
  logic [W-1:0] w_next;

  assign w_next  = r_count + W'(1);
  assign o_count = r_count;
  assign o_last  = (w_next == r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_len   <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_len   <= i_len;
    end else if (i_inc && (r_count != r_len)) begin
      // saturate at the loaded length so the count never wraps
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/avalon_burst_master.sv
// rtl/avalon_burst_master.sv - single-command Avalon-MM burst read/write master
// Optional stall watchdog enabled by defining AVALON_MASTER_BURST_TIMEOUT_EN.
module avalon_burst_master
  import avalon_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BCNT_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              read,
  output logic              beginbursttransfer,
  output logic [BCNT_W-1:0] burstcount,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  input  logic              waitrequest,
  input  logic [1:0]        response
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [BCNT_W-1:0] r_burst;
  logic              r_err;

  logic              w_accept;
  logic              w_len_ok;
  logic              w_wr_beat;
  logic              w_rd_req_ok;
  logic              w_rd_beat;
  logic              w_progress;
  logic              w_timeout;
  logic [BCNT_W-1:0] w_count;
  logic              w_last;

  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  assign w_len_ok    = len_valid(cmd_len, MAX_BURST);
  assign w_wr_beat   = (r_state == ST_WR_BURST) && wr_valid && !waitrequest;
  assign w_rd_req_ok = (r_state == ST_RD_REQ) && !waitrequest;
  assign w_rd_beat   = (r_state == ST_RD_DATA) && readdatavalid;
  assign w_progress  = w_wr_beat || w_rd_req_ok || w_rd_beat;

  burst_beat_counter #(.W(BCNT_W)) u_beat_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_len   (cmd_len),
    .i_inc   (w_wr_beat || w_rd_beat),
    .o_count (w_count),
    .o_last  (w_last)
  );

`ifdef AVALON_MASTER_BURST_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0] r_wdog;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (r_state == ST_IDLE || r_state == ST_FINISH || w_progress) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign w_timeout = (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) && !w_progress;
`else
  // no watchdog: a stalled slave is waited on indefinitely
  assign w_timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_burst <= cmd_len;
            r_err   <= !w_len_ok;
            if (!w_len_ok)      r_state <= ST_FINISH;
            else if (cmd_write) r_state <= ST_WR_BURST;
            else                r_state <= ST_RD_REQ;
          end
        end
        ST_WR_BURST: begin
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end else if (w_wr_beat && w_last) begin
            r_state <= ST_FINISH;
          end
        end
        ST_RD_REQ: begin
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end else if (w_rd_req_ok) begin
            r_state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (w_rd_beat) begin
            if (response != RESP_OKAY) r_err <= 1'b1;
            if (w_last)                r_state <= ST_FINISH;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready          = (r_state == ST_IDLE);
  assign write              = (r_state == ST_WR_BURST) && wr_valid;
  assign writedata          = write ? wr_data : '0;
  assign wr_ready           = w_wr_beat;
  assign read               = (r_state == ST_RD_REQ);
  // the first beat may sit under waitrequest, so the strobe follows the beat count, not a cycle
  assign beginbursttransfer = read || (write && (w_count == '0));
  assign address            = r_addr;
  assign burstcount         = r_burst;
  assign rd_valid           = w_rd_beat;
  assign rd_data            = readdata;
  assign done               = (r_state == ST_FINISH);
  assign err                = r_err;

endmodule

// File: tb/tb_avalon_burst_master.sv
// tb/tb_avalon_burst_master.sv - directed self-checking bench for avalon_burst_master
module tb_avalon_burst_master;
  import avalon_pkg::*;

`ifdef AVALON_MASTER_BURST_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [12:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, err;
  logic [12:0] address;
  logic        write, read, beginbursttransfer;
  logic [9:0]  burstcount;
  logic [31:0] writedata, readdata;
  logic        readdatavalid, waitrequest;
  logic [1:0]  response;

  int n_tests = 0;
  int n_fail  = 0;

  avalon_burst_master #(.TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .address(address), .write(write), .read(read),
    .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .response(response)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; readdata = '0; readdatavalid = 0;
    waitrequest = 0; response = 2'b00;
    repeat (2) tick();
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_write", 32'(write), 0);
    chk("rst_read", 32'(read), 0);
    chk("rst_bbt", 32'(beginbursttransfer), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_burstcount", 32'(burstcount), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    reset = 1'b0;

    // write burst addr 4126 len 4, no waitstates
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 13'd4126; cmd_len = 10'd4;
    wr_valid = 1; wr_data = 32'd1;
    #1;
    chk("w1_idle_write", 32'(write), 0);
    tick();
    cmd_valid = 0;
    #1;
    chk("w1_write", 32'(write), 1);
    chk("w1_bbt_first", 32'(beginbursttransfer), 1);
    chk("w1_address", 32'(address), 4126);
    chk("w1_burstcount", 32'(burstcount), 4);
    chk("w1_writedata", writedata, 1);
    chk("w1_wr_ready", 32'(wr_ready), 1);
    chk("w1_cmd_ready", 32'(cmd_ready), 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      wr_data = 32'(i);
      #1;
      chk("w1_beat_write", 32'(write), 1);
      chk("w1_beat_bbt", 32'(beginbursttransfer), 0);
      chk("w1_beat_data", writedata, 32'(i));
    end
    tick();
    wr_valid = 0;
    #1;
    chk("w1_done", 32'(done), 1);
    chk("w1_write_off", 32'(write), 0);
    chk("w1_err", 32'(err), 0);
    tick();
    chk("w1_done_pulse", 32'(done), 0);
    chk("w1_ready_again", 32'(cmd_ready), 1);

    // read addr 0 len 3, waitrequest for 2 cycles
    cmd_valid = 1; cmd_write = 0; cmd_addr = 13'd0; cmd_len = 10'd3; waitrequest = 1;
    tick();
    cmd_valid = 0;
    #1;
    chk("r1_read_c1", 32'(read), 1);
    chk("r1_bbt_c1", 32'(beginbursttransfer), 1);
    chk("r1_burstcount", 32'(burstcount), 3);
    tick();
    chk("r1_read_c2", 32'(read), 1);
    tick();
    waitrequest = 0;
    #1;
    chk("r1_read_c3", 32'(read), 1);
    chk("r1_bbt_c3", 32'(beginbursttransfer), 1);
    tick();
    chk("r1_read_off", 32'(read), 0);
    chk("r1_bbt_off", 32'(beginbursttransfer), 0);
    readdatavalid = 1; readdata = 32'hAA;
    #1;
    chk("r1_rv_aa", 32'(rd_valid), 1);
    chk("r1_rd_aa", rd_data, 32'hAA);
    tick();
    readdata = 32'hBB;
    #1;
    chk("r1_rd_bb", rd_data, 32'hBB);
    chk("r1_rv_bb", 32'(rd_valid), 1);
    tick();
    readdata = 32'hCC;
    #1;
    chk("r1_rd_cc", rd_data, 32'hCC);
    tick();
    readdata = 32'hDD;
    #1;
    chk("r1_stray_rv", 32'(rd_valid), 0);
    chk("r1_done", 32'(done), 1);
    chk("r1_err", 32'(err), 0);
    readdatavalid = 0;
    tick();

    // write len 4 with first-beat waitstate and a 3-cycle wr_valid gap
    cmd_valid = 1; cmd_write = 1; cmd_addr = 13'd100; cmd_len = 10'd4;
    wr_valid = 1; wr_data = 32'h11; waitrequest = 1;
    tick();
    cmd_valid = 0;
    #1;
    chk("w2_bbt_wait", 32'(beginbursttransfer), 1);
    chk("w2_wr_ready_wait", 32'(wr_ready), 0);
    tick();
    waitrequest = 0;
    #1;
    chk("w2_bbt_held", 32'(beginbursttransfer), 1);
    chk("w2_wr_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("w2_gap_write", 32'(write), 0);
      chk("w2_gap_bbt", 32'(beginbursttransfer), 0);
      chk("w2_gap_addr", 32'(address), 100);
      chk("w2_gap_bcnt", 32'(burstcount), 4);
      tick();
    end
    wr_valid = 1; wr_data = 32'h22;
    #1;
    chk("w2_resume_write", 32'(write), 1);
    chk("w2_resume_bbt", 32'(beginbursttransfer), 0);
    tick();
    wr_data = 32'h33;
    #1;
    chk("w2_not_done_b3", 32'(done), 0);
    tick();
    wr_data = 32'h44;
    #1;
    chk("w2_b4_data", writedata, 32'h44);
    tick();
    wr_valid = 0;
    #1;
    chk("w2_done", 32'(done), 1);
    tick();

    // read len 2, second beat SLVERR
    cmd_valid = 1; cmd_write = 0; cmd_addr = 13'd7; cmd_len = 10'd2;
    tick();
    cmd_valid = 0;
    #1;
    chk("r2_read", 32'(read), 1);
    tick();
    readdatavalid = 1; readdata = 32'h1234; response = 2'b00;
    #1;
    chk("r2_rv1", 32'(rd_valid), 1);
    chk("r2_err_b1", 32'(err), 0);
    tick();
    readdata = 32'h5678; response = 2'b10;
    #1;
    chk("r2_rv2", 32'(rd_valid), 1);
    chk("r2_rd2", rd_data, 32'h5678);
    tick();
    readdatavalid = 0; response = 2'b00;
    #1;
    chk("r2_done", 32'(done), 1);
    chk("r2_err", 32'(err), 1);
    tick();
    chk("r2_err_sticky1", 32'(err), 1);
    tick();
    chk("r2_err_sticky2", 32'(err), 1);

    // illegal lengths 0 and 600
    cmd_valid = 1; cmd_write = 1; cmd_len = 10'd0; wr_valid = 1;
    tick();
    cmd_valid = 0;
    #1;
    chk("l0_write", 32'(write), 0);
    chk("l0_read", 32'(read), 0);
    chk("l0_done", 32'(done), 1);
    chk("l0_err", 32'(err), 1);
    tick();
    cmd_valid = 1; cmd_write = 0; cmd_len = 10'd600;
    tick();
    cmd_valid = 0;
    #1;
    chk("l600_read", 32'(read), 0);
    chk("l600_done", 32'(done), 1);
    chk("l600_err", 32'(err), 1);
    wr_valid = 0;
    tick();

    // reset in the middle of an 8-beat write
    cmd_valid = 1; cmd_write = 1; cmd_addr = 13'h55; cmd_len = 10'd8;
    wr_valid = 1; wr_data = 32'hA0;
    tick();
    cmd_valid = 0;
    #1;
    chk("w8_err_cleared", 32'(err), 0);
    chk("w8_bbt", 32'(beginbursttransfer), 1);
    tick();
    tick();
    chk("w8_mid_write", 32'(write), 1);
    reset = 1'b1;
    #1;
    chk("mrst_write", 32'(write), 0);
    chk("mrst_read", 32'(read), 0);
    chk("mrst_bbt", 32'(beginbursttransfer), 0);
    chk("mrst_address", 32'(address), 0);
    chk("mrst_burstcount", 32'(burstcount), 0);
    chk("mrst_writedata", writedata, 0);
    chk("mrst_wr_ready", 32'(wr_ready), 0);
    chk("mrst_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_cmd_ready", 32'(cmd_ready), 1);
    chk("mrst_no_resume", 32'(write), 0);
    wr_valid = 0;

`ifdef AVALON_MASTER_BURST_TIMEOUT_EN
    begin
      int n;
      tick();
      cmd_valid = 1; cmd_write = 0; cmd_addr = 13'd9; cmd_len = 10'd1; waitrequest = 1;
      tick();
      cmd_valid = 0;
      n = 0;
      while (read === 1'b1 && n < 100) begin
        n++;
        tick();
      end
      chk("to_read_cycles", 32'(n), 16);
      chk("to_done", 32'(done), 1);
      chk("to_err", 32'(err), 1);
      waitrequest = 0;
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
